// File: rtl/alu_defs_pkg.sv
// rtl/alu_defs_pkg.sv - opcodes, FSM encodings, flag indices and the combinational ALU evaluator
package alu_defs_pkg;

    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_SHL   = 3'd5;
    localparam logic [2:0] OP_SHR   = 3'd6;
    localparam logic [2:0] OP_PASSB = 3'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             c;
        logic             v;
    } alu_out_t;

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = (r == '0);
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    // Shifts run in 17 bits so the carry is simply the extra bit; amt=0 leaves it clear.
    function automatic alu_out_t alu_eval(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b, input logic [AMT_W-1:0] amt);
        alu_out_t       o;
        logic [WIDTH:0] wide;
        o    = '0;
        wide = '0;
        case (op)
            OP_AND: o.result = a & b;
            OP_OR:  o.result = a | b;
            OP_XOR: o.result = a ^ b;
            OP_ADD: begin
                wide     = {1'b0, a} + {1'b0, b};
                o.result = wide[WIDTH-1:0];
                o.c      = wide[WIDTH];
                o.v      = (a[WIDTH-1] == b[WIDTH-1]) && (o.result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                wide     = {1'b0, a} - {1'b0, b};
                o.result = wide[WIDTH-1:0];
                o.c      = wide[WIDTH];
                o.v      = (a[WIDTH-1] != b[WIDTH-1]) && (o.result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL: begin
                wide     = {1'b0, a} << amt;
                o.result = wide[WIDTH-1:0];
                o.c      = wide[WIDTH];
            end
            OP_SHR: begin
                wide     = {a, 1'b0} >> amt;
                o.result = wide[WIDTH:1];
                o.c      = wide[0];
            end
            default: o.result = b;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// rtl/alu_shift_iter.sv - one-bit-per-cycle shifter: work register, down-counter, carry capture
module alu_shift_iter
    import alu_defs_pkg::*;
#(
    parameter int W  = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          shr,
    input  logic [W-1:0]  a,
    input  logic [AW-1:0] amt,
    output logic          last,
    output logic [W-1:0]  nxt_result,
    output logic          nxt_carry
);

    logic [W-1:0]  work;
    logic [AW-1:0] cnt;
    logic          dir_r;

    // The owner commits nxt_* on the edge that performs the final shift.
    assign last       = (cnt == AW'(1));
    assign nxt_result = dir_r ? (work >> 1) : (work << 1);
    assign nxt_carry  = dir_r ? work[0] : work[W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work  <= '0;
            cnt   <= '0;
            dir_r <= 1'b0;
        end else if (start) begin
            work  <= a;
            cnt   <= amt;
            dir_r <= shr;
        end else if (cnt != '0) begin
            work <= nxt_result;
            cnt  <= cnt - AW'(1);
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - ALU sequencing controller; ALU_SEQ_ITER_SHIFT_EN selects iterative shifts
module alu_seq_ctrl
    import alu_defs_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [AMT_W-1:0] req_amt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       flags,
    output logic             busy
);

    logic [1:0] state;
    logic       accept;
    alu_out_t   eval;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);
    assign accept    = req_valid && (state == ST_IDLE);
    assign eval      = alu_eval(req_op, req_a, req_b, req_amt);

`ifdef ALU_SEQ_ITER_SHIFT_EN
    logic             iter_start;
    logic             sh_last;
    logic [WIDTH-1:0] sh_result;
    logic             sh_carry;

    assign iter_start = accept && ((req_op == OP_SHL) || (req_op == OP_SHR)) && (req_amt != '0);

    alu_shift_iter #(.W(WIDTH), .AW(AMT_W)) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (iter_start),
        .shr        (req_op == OP_SHR),
        .a          (req_a),
        .amt        (req_amt),
        .last       (sh_last),
        .nxt_result (sh_result),
        .nxt_carry  (sh_carry)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rsp_result <= '0;
            flags      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
`ifdef ALU_SEQ_ITER_SHIFT_EN
                        if (iter_start) begin
                            state <= ST_SHIFT;
                        end else begin
                            rsp_result <= eval.result;
                            flags      <= mk_flags(eval.result, eval.c, eval.v);
                            state      <= ST_RESP;
                        end
`else
                        rsp_result <= eval.result;
                        flags      <= mk_flags(eval.result, eval.c, eval.v);
                        state      <= ST_RESP;
`endif
                    end
                end
`ifdef ALU_SEQ_ITER_SHIFT_EN
                ST_SHIFT: begin
                    if (sh_last) begin
                        rsp_result <= sh_result;
                        flags      <= mk_flags(sh_result, sh_carry, 1'b0);
                        state      <= ST_RESP;
                    end
                end
`endif
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
